// File: rtl/out_spike_buf_pkg.sv
// Shared parameters and AER packet layout for the neuron output stage and router.
package out_spike_buf_pkg;

    localparam int unsigned AER_BIT_WIDTH  = 32;
    localparam int unsigned FIFO_DEPTH     = 4;
    localparam int unsigned PTR_BIT_WIDTH  = 2;
    localparam int unsigned DROP_CNT_WIDTH = 8;

    // AER packet layout: destination in the upper half, neuron ID in the lower half.
    localparam int unsigned AER_NEURON_ID_LSB   = 0;
    localparam int unsigned AER_NEURON_ID_WIDTH = 16;
    localparam int unsigned AER_DEST_LSB        = 16;
    localparam int unsigned AER_DEST_WIDTH      = 16;

    typedef struct packed {
        logic [AER_DEST_WIDTH-1:0]      dest;
        logic [AER_NEURON_ID_WIDTH-1:0] neuronId;
    } aerPkt_t;

    function automatic logic [AER_DEST_WIDTH-1:0] aerDest(input logic [AER_BIT_WIDTH-1:0] pkt);
        return pkt[AER_DEST_LSB +: AER_DEST_WIDTH];
    endfunction

    function automatic logic [AER_NEURON_ID_WIDTH-1:0] aerNeuronId(input logic [AER_BIT_WIDTH-1:0] pkt);
        return pkt[AER_NEURON_ID_LSB +: AER_NEURON_ID_WIDTH];
    endfunction

endpackage

// File: rtl/out_spike_buf_aer_sync_fifo.sv
// Synchronous FIFO for AER packets: storage, pointers, occupancy and push/pop arbitration.
// A push while full is accepted only if a pop frees a slot on the same edge.
module aer_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  pushReq,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  popReq,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  full,
    output logic                  empty,
    output logic                  dropPulse
);

    localparam logic [PTR_WIDTH:0] OCC_FULL = (PTR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  rdPtr;
    logic [PTR_WIDTH:0]    occ;
    logic [PTR_WIDTH:0]    occNext;
    logic                  fullQ;
    logic                  emptyQ;
    logic                  wrEn;
    logic                  rdEn;

    // Arbitrate push/pop against the registered flags and derive next occupancy.
    always_comb begin
        rdEn    = popReq & ~emptyQ;
        wrEn    = pushReq & (~fullQ | rdEn);
        occNext = occ;
        if (wrEn && !rdEn) begin
            occNext = occ + 1'b1;
        end else if (!wrEn && rdEn) begin
            occNext = occ - 1'b1;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            occ    <= '0;
            fullQ  <= 1'b0;
            emptyQ <= 1'b1;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (rdEn) rdPtr <= rdPtr + 1'b1;
            occ    <= occNext;
            fullQ  <= (occNext == OCC_FULL);
            emptyQ <= (occNext == '0);
        end
    end

    // Packet storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr] <= wrData;
    end

    // Head is forced to zero while empty so stale storage never leaks to the router.
    assign rdData    = emptyQ ? '0 : mem[rdPtr];
    assign full      = fullQ;
    assign empty     = emptyQ;
    assign dropPulse = pushReq & ~wrEn;

endmodule

// File: rtl/out_spike_buf.sv
// Neuron output stage: queues spike packets for the router over valid/ready,
// counts packets lost to overflow and flags time steps that start with spikes still queued.
module out_spike_buf
    import out_spike_buf_pkg::*;
#(
    parameter int unsigned AER_BIT_WIDTH  = out_spike_buf_pkg::AER_BIT_WIDTH,
    parameter int unsigned FIFO_DEPTH     = out_spike_buf_pkg::FIFO_DEPTH,
    parameter int unsigned PTR_BIT_WIDTH  = out_spike_buf_pkg::PTR_BIT_WIDTH,
    parameter int unsigned DROP_CNT_WIDTH = out_spike_buf_pkg::DROP_CNT_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic                      outSpike_i,
    input  logic [AER_BIT_WIDTH-1:0]  SpikePacket_i,
    output logic [AER_BIT_WIDTH-1:0]  pkt_o,
    output logic                      pkt_valid_o,
    input  logic                      pkt_ready_i,
    output logic                      fifo_full_o,
    output logic                      fifo_empty_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic                      stepLate_o
);

    logic                      fifoFull;
    logic                      fifoEmpty;
    logic                      dropPulse;
    logic [DROP_CNT_WIDTH-1:0] dropCnt;
    logic                      stepLate;

    aer_sync_fifo #(
        .DATA_WIDTH (AER_BIT_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_BIT_WIDTH)
    ) uFifo (
        .clk       (clk_i),
        .rstN      (rst_n_i),
        .pushReq   (outSpike_i),
        .wrData    (SpikePacket_i),
        .popReq    (pkt_ready_i),
        .rdData    (pkt_o),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .dropPulse (dropPulse)
    );

    // Saturating count of packets discarded because the queue was full.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dropCnt <= '0;
        end else if (dropPulse && (dropCnt != '1)) begin
            dropCnt <= dropCnt + 1'b1;
        end
    end

    // One-cycle flag when a new time step starts with packets still queued.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stepLate <= 1'b0;
        end else begin
            stepLate <= start_i & ~fifoEmpty;
        end
    end

    assign pkt_valid_o  = ~fifoEmpty;
    assign fifo_full_o  = fifoFull;
    assign fifo_empty_o = fifoEmpty;
    assign drop_cnt_o   = dropCnt;
    assign stepLate_o   = stepLate;

endmodule

// File: tb/tb_out_spike_buf.sv
// Directed self-checking bench for out_spike_buf.
module tb_out_spike_buf;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        outSpike_i;
    logic [31:0] SpikePacket_i;
    logic [31:0] pkt_o;
    logic        pkt_valid_o;
    logic        pkt_ready_i;
    logic        fifo_full_o;
    logic        fifo_empty_o;
    logic [7:0]  drop_cnt_o;
    logic        stepLate_o;

    int unsigned nCmp = 0;
    int unsigned nErr = 0;

    out_spike_buf #(
        .AER_BIT_WIDTH  (32),
        .FIFO_DEPTH     (4),
        .PTR_BIT_WIDTH  (2),
        .DROP_CNT_WIDTH (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .outSpike_i    (outSpike_i),
        .SpikePacket_i (SpikePacket_i),
        .pkt_o         (pkt_o),
        .pkt_valid_o   (pkt_valid_o),
        .pkt_ready_i   (pkt_ready_i),
        .fifo_full_o   (fifo_full_o),
        .fifo_empty_o  (fifo_empty_o),
        .drop_cnt_o    (drop_cnt_o),
        .stepLate_o    (stepLate_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic pushOne(input logic [31:0] p);
        outSpike_i    = 1'b1;
        SpikePacket_i = p;
        tick();
        outSpike_i    = 1'b0;
    endtask

    logic [15:0] spikePat;
    logic [15:0] readyPat;
    logic [31:0] q[$];
    logic [31:0] nextPkt;
    logic        popNow;

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; outSpike_i = 1'b0;
        SpikePacket_i = '0; pkt_ready_i = 1'b0;
        tick();
        tick();
        // Reset values
        chk("rst_valid", {31'b0, pkt_valid_o}, 32'd0);
        chk("rst_empty", {31'b0, fifo_empty_o}, 32'd1);
        chk("rst_full",  {31'b0, fifo_full_o}, 32'd0);
        chk("rst_drop",  {24'b0, drop_cnt_o}, 32'd0);
        chk("rst_late",  {31'b0, stepLate_o}, 32'd0);
        chk("rst_pkt",   pkt_o, 32'd0);
        rst_n_i = 1'b1;
        tick();

        // 1: single spike, one-cycle latency, single pop
        pushOne(32'hA5A5_0001);
        chk("t1_valid", {31'b0, pkt_valid_o}, 32'd1);
        chk("t1_pkt", pkt_o, 32'hA5A5_0001);
        tick();
        chk("t1_hold", pkt_o, 32'hA5A5_0001);
        pkt_ready_i = 1'b1;
        tick();
        pkt_ready_i = 1'b0;
        chk("t1_valid_after", {31'b0, pkt_valid_o}, 32'd0);
        chk("t1_empty_after", {31'b0, fifo_empty_o}, 32'd1);

        // 2: fill and overflow
        for (int i = 1; i <= 6; i++) begin
            pushOne(32'(i));
            if (i == 3) chk("t2_notfull3", {31'b0, fifo_full_o}, 32'd0);
            if (i == 4) chk("t2_full4", {31'b0, fifo_full_o}, 32'd1);
        end
        chk("t2_drop", {24'b0, drop_cnt_o}, 32'd2);
        chk("t2_full", {31'b0, fifo_full_o}, 32'd1);
        pkt_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_order", pkt_o, 32'(k));
            tick();
        end
        pkt_ready_i = 1'b0;
        chk("t2_empty", {31'b0, fifo_empty_o}, 32'd1);
        chk("t2_valid", {31'b0, pkt_valid_o}, 32'd0);
        chk("t2_drop_kept", {24'b0, drop_cnt_o}, 32'd2);

        // 3: full with simultaneous push and pop
        doReset();
        chk("t3_drop_rst", {24'b0, drop_cnt_o}, 32'd0);
        for (int i = 1; i <= 4; i++) pushOne(32'(i));
        chk("t3_full_pre", {31'b0, fifo_full_o}, 32'd1);
        outSpike_i = 1'b1; SpikePacket_i = 32'h9; pkt_ready_i = 1'b1;
        tick();
        outSpike_i = 1'b0; pkt_ready_i = 1'b0;
        chk("t3_drop", {24'b0, drop_cnt_o}, 32'd0);
        chk("t3_full", {31'b0, fifo_full_o}, 32'd1);
        pkt_ready_i = 1'b1;
        chk("t3_o2", pkt_o, 32'h2); tick();
        chk("t3_o3", pkt_o, 32'h3); tick();
        chk("t3_o4", pkt_o, 32'h4); tick();
        chk("t3_o9", pkt_o, 32'h9); tick();
        pkt_ready_i = 1'b0;
        chk("t3_empty", {31'b0, fifo_empty_o}, 32'd1);

        // 4: wrap-around with backpressure, 10 spikes over 16 cycles (bit 0 first)
        spikePat = 16'b0011_0110_1101_1011;
        readyPat = 16'b1101_1011_1001_1010;
        for (int c = 0; c < 16; c++) begin
            outSpike_i    = spikePat[c];
            SpikePacket_i = 32'h100 + 32'(c);
            pkt_ready_i   = readyPat[c];
            chk("t4_valid", {31'b0, pkt_valid_o}, {31'b0, q.size() != 0});
            popNow = (q.size() != 0) && readyPat[c];
            if (q.size() != 0) chk("t4_head", pkt_o, q[0]);
            if (popNow) nextPkt = q.pop_front();
            if (spikePat[c]) q.push_back(32'h100 + 32'(c));
            tick();
        end
        outSpike_i = 1'b0; pkt_ready_i = 1'b0;
        chk("t4_empty", {31'b0, fifo_empty_o}, 32'd1);
        chk("t4_drop", {24'b0, drop_cnt_o}, 32'd0);

        // 5: late time step
        pushOne(32'h51);
        pushOne(32'h52);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t5_late_hi", {31'b0, stepLate_o}, 32'd1);
        tick();
        chk("t5_late_lo", {31'b0, stepLate_o}, 32'd0);
        pkt_ready_i = 1'b1;
        chk("t5_p1", pkt_o, 32'h51); tick();
        chk("t5_p2", pkt_o, 32'h52); tick();
        pkt_ready_i = 1'b0;
        chk("t5_empty", {31'b0, fifo_empty_o}, 32'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t5_late_empty", {31'b0, stepLate_o}, 32'd0);

        // 6: async reset with 3 queued packets and a nonzero drop count
        for (int i = 0; i < 5; i++) pushOne(32'h61 + 32'(i));
        chk("t6_drop_pre", {24'b0, drop_cnt_o}, 32'd1);
        pkt_ready_i = 1'b1;
        tick();
        pkt_ready_i = 1'b0;
        chk("t6_head_pre", pkt_o, 32'h62);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t6_valid", {31'b0, pkt_valid_o}, 32'd0);
        chk("t6_empty", {31'b0, fifo_empty_o}, 32'd1);
        chk("t6_drop", {24'b0, drop_cnt_o}, 32'd0);
        chk("t6_pkt", pkt_o, 32'd0);
        tick();
        rst_n_i = 1'b1;
        tick();
        pushOne(32'h77);
        chk("t6_new", pkt_o, 32'h77);
        pkt_ready_i = 1'b1;
        tick();
        pkt_ready_i = 1'b0;
        chk("t6_only", {31'b0, fifo_empty_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
